ext_stream_unit: RTL



---
 rtl/ext_pkg.sv | 39 +++
 rtl/ext_core.sv | 121 ++++++++++++
 rtl/ext_stream_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ext_pkg.sv
// ---------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the registered extension unit.
//   - EXT_ZERO..EXT_LW : 3-bit operation encodings driven on in_mode
//   - ext_state_t      : occupancy states of the two-entry output buffer
//   - is_misaligned    : alignment rule for half/word loads
// No ports (package).
// ---------------------------------------------------------------------------
package ext_pkg;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;
  localparam logic [2:0] EXT_LBU  = 3'd3;
  localparam logic [2:0] EXT_LB   = 3'd4;
  localparam logic [2:0] EXT_LHU  = 3'd5;
  localparam logic [2:0] EXT_LH   = 3'd6;
  localparam logic [2:0] EXT_LW   = 3'd7;

  // Number of valid entries held: output reg only, or output reg plus skid reg.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_t;

  // Halves must sit on an even byte offset, words on offset zero.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (mode)
      EXT_LHU, EXT_LH: res = addr_lo[0];
      EXT_LW:          res = (addr_lo != 2'd0);
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ext_core.sv
// ---------------------------------------------------------------------------
// ext_core
// Purely combinational extension datapath: picks the byte/half lane of a
// load word (little-endian), or the immediate, and zero/sign extends it.
// Optional macro EXT_ALIGN_CHK_EN: misaligned LH/LHU/LW yield exc=1, data=0.
// Without it exc is tied low and misaligned accesses use the aligned lane.
// Ports:
//   mode     in  3       operation (ext_pkg encodings)
//   imm      in  IMM_W   immediate operand
//   word     in  DATA_W  raw load word; lanes taken from the low 32 bits
//   addr_lo  in  2       byte offset of the load address
//   data     out DATA_W  extended result
//   exc      out 1       alignment fault
// ---------------------------------------------------------------------------
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data,
  output logic              exc
);

  // Fill with the sign (or zero), then overwrite the low bits: works for any DATA_W
  // without zero-width replications.
  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r      = {DATA_W{sgn & v[7]}};
    r[7:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{sgn & v[15]}};
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ext32(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] raw_s;

  // Byte lane select by byte offset.
  always_comb begin
    byte_s = 8'd0;
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // Half lane select; only addr_lo[1] matters, so a misaligned half reads its aligned lane.
  always_comb begin
    half_s = 16'd0;
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Per-mode extension.
  always_comb begin
    raw_s = '0;
    case (mode)
      EXT_ZERO: begin
        raw_s            = '0;
        raw_s[IMM_W-1:0] = imm;
      end
      EXT_SIGN: begin
        raw_s            = {DATA_W{imm[IMM_W-1]}};
        raw_s[IMM_W-1:0] = imm;
      end
      EXT_LUI: begin
        raw_s                    = '0;
        raw_s[DATA_W-1 -: IMM_W] = imm;
      end
      EXT_LBU: raw_s = ext8(byte_s, 1'b0);
      EXT_LB:  raw_s = ext8(byte_s, 1'b1);
      EXT_LHU: raw_s = ext16(half_s, 1'b0);
      EXT_LH:  raw_s = ext16(half_s, 1'b1);
      EXT_LW:  raw_s = ext32(word[31:0]);
      default: raw_s = '0;
    endcase
  end

`ifdef EXT_ALIGN_CHK_EN
  // Faulting accesses return zero data with the fault flag set.
  always_comb begin
    data = '0;
    exc  = 1'b0;
    if (is_misaligned(mode, addr_lo)) begin
      data = '0;
      exc  = 1'b1;
    end else begin
      data = raw_s;
      exc  = 1'b0;
    end
  end
`else
  assign data = raw_s;
  assign exc  = 1'b0;
`endif

endmodule

// File: rtl/ext_stream_unit.sv
// ---------------------------------------------------------------------------
// ext_stream_unit
// Registered immediate/load-data extender behind a valid/ready handshake with
// a two-entry buffer (output reg + skid reg). A push is visible on out_* the
// next cycle when the output reg is free; order is strictly FIFO.
// Optional macro EXT_ALIGN_CHK_EN enables the alignment fault on out_exc.
// Ports:
//   clk         in  1       rising-edge clock
//   reset       in  1       synchronous, active-high
//   in_valid    in  1       request present
//   in_ready    out 1       unit can accept (registered)
//   in_mode     in  3       operation (ext_pkg encodings)
//   in_imm      in  IMM_W   immediate operand
//   in_word     in  DATA_W  raw memory word for load modes
//   in_addr_lo  in  2       byte offset of the load address
//   out_valid   out 1       result present
//   out_ready   in  1       consumer accepts
//   out_data    out DATA_W  extended result
//   out_exc     out 1       alignment fault flag
// ---------------------------------------------------------------------------
module ext_stream_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [1:0]        in_addr_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_exc
);

  ext_state_t        state_r;
  ext_state_t        next_state_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_exc_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_exc_r;
  logic [DATA_W-1:0] res_data_s;
  logic              res_exc_s;
  logic              push_s;
  logic              pop_s;
  logic              load_out_s;
  logic              load_skid_s;
  logic              out_from_skid_s;

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .mode    (in_mode),
    .imm     (in_imm),
    .word    (in_word),
    .addr_lo (in_addr_lo),
    .data    (res_data_s),
    .exc     (res_exc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; TWO never sees a push because in_ready is low there.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          next_state_s = ST_ONE;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && !pop_s) begin
          next_state_s = ST_TWO;
        end else if (pop_s && !push_s) begin
          next_state_s = ST_EMPTY;
        end else begin
          next_state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          next_state_s = ST_ONE;
        end else begin
          next_state_s = ST_TWO;
        end
      end
      default: next_state_s = ST_EMPTY;
    endcase
  end

  // Output/datapath control decoded from state and handshakes.
  always_comb begin
    load_out_s      = 1'b0;
    load_skid_s     = 1'b0;
    out_from_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          load_out_s = 1'b1;
        end else begin
          load_out_s = 1'b0;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          load_out_s = 1'b1;
        end else if (push_s) begin
          load_skid_s = 1'b1;
        end else begin
          load_out_s  = 1'b0;
          load_skid_s = 1'b0;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          load_out_s      = 1'b1;
          out_from_skid_s = 1'b1;
        end else begin
          load_out_s      = 1'b0;
          out_from_skid_s = 1'b0;
        end
      end
      default: begin
        load_out_s      = 1'b0;
        load_skid_s     = 1'b0;
        out_from_skid_s = 1'b0;
      end
    endcase
  end

  // Handshake flags registered from the next state so they line up with the buffer contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s != ST_TWO);
      out_valid_r <= (next_state_s != ST_EMPTY);
    end
  end

  // Output and skid registers; the output reg holds whenever it is not reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_exc_r   <= 1'b0;
      skid_data_r <= '0;
      skid_exc_r  <= 1'b0;
    end else begin
      if (load_out_s) begin
        if (out_from_skid_s) begin
          out_data_r <= skid_data_r;
          out_exc_r  <= skid_exc_r;
        end else begin
          out_data_r <= res_data_s;
          out_exc_r  <= res_exc_s;
        end
      end
      if (load_skid_s) begin
        skid_data_r <= res_data_s;
        skid_exc_r  <= res_exc_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_exc   = out_exc_r;

endmodule
